wm8731_config_seq: RTL and testbench
====================================

WM8731_CONFIG_SEQ -- requirements
Module: wm8731_config_seq

Interface
REQ-001 Parameter NUM_REGS, default 10, number of codec register words written per sequence (1..16).
REQ-002 Parameter GAP_CYCLES, default 2048, MCLK cycles I2C_ENABLE is held low between writes; minimum 1024, i.e. two writer bit periods.
REQ-003 Parameter TIMEOUT_CYCLES, default 65536, MCLK cycles allowed per write before abort.
REQ-004 MCLK  input  1  system clock; the only clock.
REQ-005 RESET  input  1  synchronous, active-low reset, sampled on rising MCLK.
REQ-006 START  input  1  level; a rising edge starts a configuration sequence.
REQ-007 I2C_FINISHED  input  1  write-complete level from the I2C writer.
REQ-008 I2C_ENABLE  output  1  enable to the I2C writer; high holds a transfer active.
REQ-009 I2C_DATA  output  16  register word: [15:9] register address, [8:0] value.
REQ-010 BUSY  output  1  high while a sequence is in progress.
REQ-011 DONE  output  1  high after a sequence ends; cleared by the next START edge.
REQ-012 ERROR  output  1  high when the last sequence aborted on timeout.
REQ-013 INDEX  output  4  index of the current, or last attempted, table entry.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, XFER, GAP, FIN.
REQ-015 IDLE: a START rising edge (registered START 0 -> 1) SHALL go to LOAD with INDEX=0, ERROR=0, DONE=0, BUSY=1.
REQ-016 LOAD: I2C_DATA SHALL take table[INDEX]; next cycle XFER; I2C_DATA SHALL stay stable until the next LOAD.
REQ-017 XFER: I2C_ENABLE=1; the timeout counter increments every cycle.
REQ-018 I2C_FINISHED SHALL pass through a 2-flop synchronizer; only a synchronized 0 -> 1 transition counts as completion.
REQ-019 XFER completion SHALL go to GAP, drop I2C_ENABLE the same cycle, and clear the gap counter.
REQ-020 GAP: I2C_ENABLE=0 for exactly GAP_CYCLES cycles.
REQ-021 End of GAP with INDEX < NUM_REGS-1: INDEX increments, next state LOAD.
REQ-022 End of GAP with INDEX = NUM_REGS-1: next state FIN.
REQ-023 XFER timeout counter reaching TIMEOUT_CYCLES-1 without completion SHALL set ERROR=1, drop I2C_ENABLE, and go to FIN; INDEX holds the failing entry.
REQ-024 FIN: BUSY=0, DONE=1; a START rising edge SHALL behave as REQ-015.
REQ-025 START edges SHALL be ignored in LOAD, XFER and GAP.
REQ-026 A completion edge arriving in any state other than XFER SHALL be ignored.
REQ-027 Completion and timeout in the same cycle: completion SHALL win.
REQ-028 Counters SHALL saturate and never wrap.
REQ-029 Counter widths SHALL be $clog2 of the corresponding parameter.
REQ-030 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-031 RESET=0 SHALL force: state IDLE, I2C_ENABLE=0, I2C_DATA=16'h0000, BUSY=0, DONE=0, ERROR=0, INDEX=0, all counters 0, synchronizer and START edge registers 0.
REQ-032 Reset during XFER SHALL drop I2C_ENABLE on that same clock edge; no partial sequence resumes.

Structure
REQ-033 Package wm8731_cfg_pkg SHALL hold: the state enum; the register table as a 16x16 constant array; and the default register words:
- 0x1E00 reset
- 0x0017 left line in
- 0x0217 right line in
- 0x0479 left headphone
- 0x0679 right headphone
- 0x0812 analogue path
- 0x0A00 digital path
- 0x0C00 power
- 0x0E42 format
- 0x1001 sampling
- 0x1201 active
REQ-034 The top module SHALL drive I2C_ENABLE, I2C_DATA and I2C_FINISHED directly and SHALL NOT instantiate the I2C writer.
REQ-035 One sub-module, cfg_sync_edge (2-flop synchronizer plus rising-edge detect), SHALL be used for both START and I2C_FINISHED.

Verification
REQ-036 Reset, then pulse START; model FINISHED 3000 cycles after each ENABLE rise -> 10 writes in table order, I2C_DATA=0x1E00 on the first write; then DONE=1, BUSY=0, ERROR=0, INDEX=9.
REQ-037 After each completion -> I2C_ENABLE low for exactly 2048 cycles before the next rise.
REQ-038 Never assert FINISHED on the 3rd write -> ERROR=1, DONE=1, INDEX=2, I2C_ENABLE=0 after 65536 cycles.
REQ-039 Assert RESET during the 5th XFER -> I2C_ENABLE=0 next edge, all outputs at reset values; a later START restarts from INDEX=0.
REQ-040 Toggle START mid-sequence, and pulse FINISHED during GAP -> no effect on sequence order or counts.
REQ-041 Drive START from FIN -> DONE clears, a new full sequence runs, ERROR cleared.

Source files
------------

// File: rtl/wm8731_cfg_pkg.sv
// WM8731 configuration package.
// Holds the sequencer state encoding and the codec register table. Each
// table word is {register address[6:0], value[8:0]}. Entries past the
// defined words are zero and only used if NUM_REGS is raised past 11.
package wm8731_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_XFER,
        ST_GAP,
        ST_FIN
    } cfg_state_t;

    localparam logic [15:0] REG_TABLE [16] = '{
        16'h1E00,  // reset
        16'h0017,  // left line in
        16'h0217,  // right line in
        16'h0479,  // left headphone
        16'h0679,  // right headphone
        16'h0812,  // analogue path
        16'h0A00,  // digital path
        16'h0C00,  // power
        16'h0E42,  // format
        16'h1001,  // sampling
        16'h1201,  // active
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000,
        16'h0000
    };

endpackage

// File: rtl/cfg_sync_edge.sv
// Two-flop synchronizer with rising-edge detect.
// Ports:
//   gclk   - clock
//   grst_n - synchronous active-low reset
//   din    - asynchronous level input
//   rise   - one-cycle pulse on a synchronized 0 -> 1 transition
module cfg_sync_edge (
    input  logic gclk,
    input  logic grst_n,
    input  logic din,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_q;

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= din;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    // Driven only by flops, so no combinational path from din.
    assign rise = sync & ~sync_q;

endmodule

// File: rtl/wm8731_config_seq.sv
// WM8731 codec configuration sequencer.
// Walks the register table, handing one word at a time to an external I2C
// writer and waiting for its completion, with a fixed idle gap between
// writes and a per-write timeout.
// Ports:
//   MCLK         - system clock
//   RESET        - synchronous active-low reset
//   START        - rising edge starts a sequence (from IDLE or FIN)
//   I2C_FINISHED - writer completion level (synchronized internally)
//   I2C_ENABLE   - holds a writer transfer active while high
//   I2C_DATA     - register word {addr[6:0], value[8:0]}
//   BUSY         - sequence in progress
//   DONE         - sequence ended (normally or on timeout)
//   ERROR        - last sequence aborted on timeout
//   INDEX        - current / last attempted table entry
module wm8731_config_seq
    import wm8731_cfg_pkg::*;
#(
    parameter int NUM_REGS       = 10,
    parameter int GAP_CYCLES     = 2048,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        START,
    input  logic        I2C_FINISHED,
    output logic        I2C_ENABLE,
    output logic [15:0] I2C_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERROR,
    output logic [3:0]  INDEX
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES);

    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CYCLES - 1);
    // The LOAD cycle also has I2C_ENABLE low, so GAP itself ends one cycle
    // early to make the low time between writes exactly GAP_CYCLES.
    localparam logic [GW-1:0] G_END    = GW'(GAP_CYCLES - 2);
    localparam logic [3:0]    LAST_IDX = 4'(NUM_REGS - 1);

    cfg_state_t    state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [GW-1:0] gcnt, gcnt_n;
    logic          enable_n;
    logic [15:0]   data_n;
    logic          busy_n, done_n, error_n;
    logic [3:0]    index_n;

    logic start_rise;
    logic fin_rise;

    cfg_sync_edge u_start_sync (
        .gclk   (MCLK),
        .grst_n (RESET),
        .din    (START),
        .rise   (start_rise)
    );

    cfg_sync_edge u_fin_sync (
        .gclk   (MCLK),
        .grst_n (RESET),
        .din    (I2C_FINISHED),
        .rise   (fin_rise)
    );

    always_ff @(posedge MCLK) begin
        if (!RESET) begin
            state      <= ST_IDLE;
            tcnt       <= '0;
            gcnt       <= '0;
            I2C_ENABLE <= 1'b0;
            I2C_DATA   <= 16'h0000;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERROR      <= 1'b0;
            INDEX      <= 4'd0;
        end else begin
            state      <= state_n;
            tcnt       <= tcnt_n;
            gcnt       <= gcnt_n;
            I2C_ENABLE <= enable_n;
            I2C_DATA   <= data_n;
            BUSY       <= busy_n;
            DONE       <= done_n;
            ERROR      <= error_n;
            INDEX      <= index_n;
        end
    end

    always_comb begin
        state_n  = state;
        tcnt_n   = tcnt;
        gcnt_n   = gcnt;
        enable_n = I2C_ENABLE;
        data_n   = I2C_DATA;
        busy_n   = BUSY;
        done_n   = DONE;
        error_n  = ERROR;
        index_n  = INDEX;

        case (state)
            ST_IDLE, ST_FIN: begin
                if (start_rise) begin
                    state_n = ST_LOAD;
                    index_n = 4'd0;
                    error_n = 1'b0;
                    done_n  = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            ST_LOAD: begin
                data_n   = REG_TABLE[INDEX];
                enable_n = 1'b1;
                tcnt_n   = '0;
                state_n  = ST_XFER;
            end
            ST_XFER: begin
                // Completion is checked first so it wins over a timeout.
                if (fin_rise) begin
                    enable_n = 1'b0;
                    gcnt_n   = '0;
                    state_n  = ST_GAP;
                end else if (tcnt == T_LAST) begin
                    enable_n = 1'b0;
                    error_n  = 1'b1;
                    busy_n   = 1'b0;
                    done_n   = 1'b1;
                    state_n  = ST_FIN;
                end else if (tcnt != '1) begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt == G_END) begin
                    if (INDEX == LAST_IDX) begin
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        state_n = ST_FIN;
                    end else begin
                        index_n = INDEX + 4'd1;
                        state_n = ST_LOAD;
                    end
                end else if (gcnt != '1) begin
                    gcnt_n = gcnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_wm8731_config_seq.sv
// Directed bench for wm8731_config_seq. A behavioural I2C writer raises
// I2C_FINISHED a fixed delay after each I2C_ENABLE rise (or never, for a
// chosen write) and logs each write's word, the enable-low time before it
// and its enable-high time.
module tb_wm8731_config_seq;

    localparam int GAP  = 2048;
    localparam int TMO  = 4096;
    localparam int DLY  = 200;

    logic        MCLK = 1'b0;
    logic        RESET = 1'b0;
    logic        START = 1'b0;
    logic        I2C_FINISHED;
    logic        I2C_ENABLE;
    logic [15:0] I2C_DATA;
    logic        BUSY;
    logic        DONE;
    logic        ERROR;
    logic [3:0]  INDEX;

    logic fin_model = 1'b0;
    logic fin_inject = 1'b0;
    assign I2C_FINISHED = fin_model | fin_inject;

    int total = 0;
    int bad = 0;

    logic [15:0] exp_words [10] = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479,
                                    16'h0679, 16'h0812, 16'h0A00, 16'h0C00,
                                    16'h0E42, 16'h1001};

    wm8731_config_seq #(
        .NUM_REGS       (10),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .MCLK         (MCLK),
        .RESET        (RESET),
        .START        (START),
        .I2C_FINISHED (I2C_FINISHED),
        .I2C_ENABLE   (I2C_ENABLE),
        .I2C_DATA     (I2C_DATA),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .ERROR        (ERROR),
        .INDEX        (INDEX)
    );

    always #5 MCLK = ~MCLK;

    // Writer model and monitor.
    int          wr_cnt = 0;
    int          fail_at = 0;
    int          hi_cnt = 0;
    int          low_cnt = 0;
    logic        en_q = 1'b0;
    logic [15:0] wlog [64];
    int          glen [64];
    int          hlen [64];

    always @(negedge MCLK) begin
        logic en;
        en = (I2C_ENABLE === 1'b1);
        if (en && !en_q) begin
            wr_cnt = wr_cnt + 1;
            wlog[wr_cnt] = I2C_DATA;
            glen[wr_cnt] = low_cnt;
            hi_cnt = 0;
        end
        if (!en && en_q) begin
            hlen[wr_cnt] = hi_cnt;
            low_cnt = 0;
        end
        if (en) begin
            hi_cnt = hi_cnt + 1;
            if (hi_cnt == DLY && wr_cnt != fail_at) fin_model = 1'b1;
        end else begin
            low_cnt = low_cnt + 1;
            fin_model = 1'b0;
        end
        en_q = en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge MCLK);
        START = 1'b1;
        repeat (4) @(negedge MCLK);
        START = 1'b0;
        repeat (4) @(negedge MCLK);
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        int i = 0;
        while (wr_cnt < n && i < budget) begin
            @(negedge MCLK);
            i++;
        end
        chk(tag, 32'(wr_cnt >= n), 32'd1);
    endtask

    task automatic wait_en_low(input string tag, input int budget);
        int i = 0;
        while (I2C_ENABLE !== 1'b0 && i < budget) begin
            @(negedge MCLK);
            i++;
        end
        chk(tag, 32'(I2C_ENABLE), 32'd0);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (DONE !== 1'b1 && i < budget) begin
            @(negedge MCLK);
            i++;
        end
        @(negedge MCLK);
        chk(tag, 32'(DONE), 32'd1);
    endtask

    initial begin
        int base;

        // Reset state.
        repeat (5) @(posedge MCLK);
        @(negedge MCLK);
        chk("rst_enable", 32'(I2C_ENABLE), 32'd0);
        chk("rst_data",   32'(I2C_DATA),   32'h0000);
        chk("rst_busy",   32'(BUSY),       32'd0);
        chk("rst_done",   32'(DONE),       32'd0);
        chk("rst_error",  32'(ERROR),      32'd0);
        chk("rst_index",  32'(INDEX),      32'd0);
        RESET = 1'b1;
        repeat (3) @(negedge MCLK);

        // Full sequence with START toggles and a stray FINISHED in a gap.
        base = wr_cnt;
        pulse_start();
        chk("s1_busy", 32'(BUSY), 32'd1);
        wait_wr("s1_wr2", base + 2, 3000);
        pulse_start();
        wait_en_low("s1_gap2", 400);
        repeat (300) @(negedge MCLK);
        fin_inject = 1'b1;
        repeat (8) @(negedge MCLK);
        fin_inject = 1'b0;
        pulse_start();
        wait_done("s1_done", 40000);
        chk("s1_busy_end",  32'(BUSY),       32'd0);
        chk("s1_error",     32'(ERROR),      32'd0);
        chk("s1_index",     32'(INDEX),      32'd9);
        chk("s1_enable",    32'(I2C_ENABLE), 32'd0);
        chk("s1_writes",    32'(wr_cnt - base), 32'd10);
        for (int k = 1; k <= 10; k++)
            chk($sformatf("s1_word%0d", k), 32'(wlog[base + k]), 32'(exp_words[k - 1]));
        for (int k = 2; k <= 10; k++)
            chk($sformatf("s1_gap%0d", k), 32'(glen[base + k]), 32'(GAP));

        // Timeout on the third write, started from FIN.
        base = wr_cnt;
        fail_at = base + 3;
        pulse_start();
        chk("t_done_clr", 32'(DONE), 32'd0);
        wait_done("t_done", 20000);
        chk("t_error",   32'(ERROR),      32'd1);
        chk("t_busy",    32'(BUSY),       32'd0);
        chk("t_index",   32'(INDEX),      32'd2);
        chk("t_enable",  32'(I2C_ENABLE), 32'd0);
        chk("t_writes",  32'(wr_cnt - base), 32'd3);
        chk("t_hi_len",  32'(hlen[base + 3]), 32'(TMO));
        chk("t_word3",   32'(wlog[base + 3]), 32'h0217);
        fail_at = 0;

        // New full sequence from FIN clears DONE and ERROR.
        base = wr_cnt;
        pulse_start();
        chk("r_done_clr",  32'(DONE),  32'd0);
        chk("r_error_clr", 32'(ERROR), 32'd0);
        chk("r_busy",      32'(BUSY),  32'd1);
        wait_done("r_done", 40000);
        chk("r_error",  32'(ERROR),  32'd0);
        chk("r_index",  32'(INDEX),  32'd9);
        chk("r_writes", 32'(wr_cnt - base), 32'd10);
        chk("r_first",  32'(wlog[base + 1]),  32'h1E00);
        chk("r_last",   32'(wlog[base + 10]), 32'h1001);

        // Reset during the fifth transfer.
        base = wr_cnt;
        pulse_start();
        wait_wr("x_wr5", base + 5, 15000);
        repeat (20) @(negedge MCLK);
        chk("x_in_xfer", 32'(I2C_ENABLE), 32'd1);
        RESET = 1'b0;
        @(posedge MCLK);
        #1;
        chk("x_enable", 32'(I2C_ENABLE), 32'd0);
        chk("x_data",   32'(I2C_DATA),   32'h0000);
        chk("x_busy",   32'(BUSY),       32'd0);
        chk("x_done",   32'(DONE),       32'd0);
        chk("x_error",  32'(ERROR),      32'd0);
        chk("x_index",  32'(INDEX),      32'd0);
        repeat (3) @(negedge MCLK);
        RESET = 1'b1;
        repeat (50) @(negedge MCLK);
        chk("x_idle_busy",   32'(BUSY),       32'd0);
        chk("x_idle_enable", 32'(I2C_ENABLE), 32'd0);
        chk("x_no_resume",   32'(wr_cnt - base), 32'd5);

        // Restart after reset begins at entry 0.
        base = wr_cnt;
        pulse_start();
        wait_wr("n_wr1", base + 1, 100);
        chk("n_word",  32'(wlog[base + 1]), 32'h1E00);
        chk("n_index", 32'(INDEX), 32'd0);
        chk("n_busy",  32'(BUSY),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
